// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Optional addi support is enabled with MC_ADDI_EN.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RTYPEWB= 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_ADDI  = 6'd8;

    localparam logic [2:0] ALUOP_FUNC = 3'b000;
    localparam logic [2:0] ALUOP_ADD  = 3'b010;
    localparam logic [2:0] ALUOP_SUB  = 3'b110;

    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle FSM and the datapath.
// master = control FSM, slave = datapath side.
interface mips_multicycle_control_if;

    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
        output IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
        output ALUSrcB, ALUOp, PCSource, IllegalOp, State
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
        input  IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
        input  ALUSrcB, ALUOp, PCSource, IllegalOp, State
    );

endinterface

// File: rtl/mips_ctrl_outdec.sv
// State-to-control decoder; Moore except IRWrite/PCWrite in FETCH.
// ADDIEX/ADDIWB decode only when MC_ADDI_EN is defined.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALUOP_ADD;
        unique case (state)
            S_IDLE: ctrl.alu_op = ALUOP_FUNC;
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            S_RTYPEWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Define MC_ADDI_EN to accept addi (opcode 8).
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    mips_multicycle_control_if.master        bus
);

    state_t state_q, state_d;
    logic   ill_q, ill_d;
    ctrl_t  ctrl;
    logic   is_mem, is_rtype, is_beq, is_j, is_addi;

    assign is_mem   = (bus.Opcode == OP_LW) || (bus.Opcode == OP_SW);
    assign is_rtype = (bus.Opcode == OP_RTYPE);
    assign is_beq   = (bus.Opcode == OP_BEQ);
    assign is_j     = (bus.Opcode == OP_J);
`ifdef MC_ADDI_EN
    assign is_addi  = (bus.Opcode == OP_ADDI);
`else
    assign is_addi  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        ill_d   = ill_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    is_mem:   state_d = S_MEMADR;
                    is_rtype: state_d = S_EXEC;
                    is_beq:   state_d = S_BRANCH;
                    is_j:     state_d = S_JUMP;
                    is_addi:  state_d = S_ADDIEX;
                    default: begin
                        state_d = S_FETCH;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            // Anything other than sw at this point is treated as a load
            S_MEMADR:  state_d = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = bus.MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:    state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (bus.MemReady),
        .ctrl      (ctrl)
    );

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.IllegalOp   = ill_q;
    assign bus.State       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control.
// Honours MC_ADDI_EN the same way as the design.
module tb_mips_multicycle_control;

    logic clk;
    logic rst_n;

    mips_multicycle_control_if bus_if ();

    mips_multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    bit model_ill;
    int obs[$];

    typedef struct {
        int st;
        bit rdy;
    } step_t;

    step_t plan[$];

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
    //  MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    function automatic logic [16:0] exp_ctrl(input int st, input bit rdy);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, pcs;
        logic [2:0] aop;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
        asb = 2'd0;
        pcs = 2'd0;
        aop = 3'b010;
        case (st)
            0: aop = 3'b000;
            1: begin mrd = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
            2: asb = 2'd3;
            3: begin asa = 1; asb = 2'd2; end
            4: begin mrd = 1; iord = 1; end
            5: begin rw = 1; m2r = 1; end
            6: begin mwr = 1; iord = 1; end
            7: begin asa = 1; aop = 3'b000; end
            8: begin rw = 1; rdst = 1; end
            9: begin asa = 1; aop = 3'b110; pcwc = 1; pcs = 2'd1; end
            10: begin pcw = 1; pcs = 2'd2; end
`ifdef MC_ADDI_EN
            11: begin asa = 1; asb = 2'd2; end
            12: rw = 1;
`endif
            default: aop = 3'b000;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa,
                asb, aop, pcs};
    endfunction

    function automatic logic [16:0] act_ctrl();
        return {bus_if.PCWrite, bus_if.PCWriteCond, bus_if.IorD,
                bus_if.MemRead, bus_if.MemWrite, bus_if.IRWrite,
                bus_if.MemtoReg, bus_if.RegDst, bus_if.RegWrite,
                bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ALUOp,
                bus_if.PCSource};
    endfunction

    // Build the expected per-cycle state trace for one instruction
    task automatic run_instr(input logic [5:0] op, input int fst,
                             input int mst, input bit abort);
        bit illegal;
        int st;
        bit rdy;
        plan.delete();
        obs.delete();
        illegal = 0;
        repeat (fst) plan.push_back('{1, 0});
        plan.push_back('{1, 1});
        plan.push_back('{2, 0});
        if (op == 6'd35) begin
            plan.push_back('{3, 0});
            repeat (mst) plan.push_back('{4, 0});
            plan.push_back('{4, 1});
            plan.push_back('{5, 0});
        end else if (op == 6'd43) begin
            plan.push_back('{3, 0});
            repeat (mst) plan.push_back('{6, 0});
            plan.push_back('{6, 1});
        end else if (op == 6'd0) begin
            plan.push_back('{7, 0});
            plan.push_back('{8, 0});
        end else if (op == 6'd4) begin
            plan.push_back('{9, 0});
        end else if (op == 6'd2) begin
            plan.push_back('{10, 0});
`ifdef MC_ADDI_EN
        end else if (op == 6'd8) begin
            plan.push_back('{11, 0});
            plan.push_back('{12, 0});
`endif
        end else begin
            illegal = 1;
        end
        foreach (plan[i]) begin
            @(negedge clk);
            st = plan[i].st;
            if (st == 1 || st == 4 || st == 6)
                bus_if.MemReady = plan[i].rdy;
            else
                bus_if.MemReady = 1'($urandom);
            if (st == 2 || st == 3)
                bus_if.Opcode = op;
            else
                bus_if.Opcode = 6'($urandom);
            rdy = bus_if.MemReady;
            #1;
            checks++;
            if (bus_if.State !== 4'(st)) begin
                errors++;
                $display("FAIL state op=%0d step=%0d act=%0d exp=%0d",
                         op, i, bus_if.State, st);
            end
            checks++;
            if (act_ctrl() !== exp_ctrl(st, rdy)) begin
                errors++;
                $display("FAIL ctrl op=%0d st=%0d act=%h exp=%h",
                         op, st, act_ctrl(), exp_ctrl(st, rdy));
            end
            checks++;
            if (bus_if.IllegalOp !== model_ill) begin
                errors++;
                $display("FAIL illegal_op op=%0d st=%0d act=%b exp=%b",
                         op, st, bus_if.IllegalOp, model_ill);
            end
            obs.push_back(int'(bus_if.State));
            if (abort && st == 6) begin
                #1 rst_n = 1'b0;
                #1;
                model_ill = 0;
                checks++;
                if (bus_if.MemWrite !== 1'b0 || bus_if.State !== 4'd0
                    || bus_if.IllegalOp !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_memwr act mw=%b st=%0d ill=%b exp 0/0/0",
                             bus_if.MemWrite, bus_if.State, bus_if.IllegalOp);
                end
                return;
            end
            if (st == 2 && illegal) model_ill = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.MemReady = 1'b1;
        bus_if.Opcode = 6'd0;
        model_ill = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus_if.State !== 4'd0 || act_ctrl() !== 17'd0
            || bus_if.IllegalOp !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold st=%0d ctrl=%h ill=%b exp 0/0/0",
                     bus_if.State, act_ctrl(), bus_if.IllegalOp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus_if.State !== 4'd0 || act_ctrl() !== 17'd0) begin
            errors++;
            $display("FAIL idle_after_reset st=%0d ctrl=%h exp 0/0",
                     bus_if.State, act_ctrl());
        end
    endtask

    task automatic test_lw();
        int exp_tr[7] = '{1, 2, 3, 4, 4, 4, 5};
        run_instr(6'd35, 0, 2, 0);
        checks++;
        if (obs.size() != 7) begin
            errors++;
            $display("FAIL lw_len act=%0d exp=7", obs.size());
        end
        for (int i = 0; i < 7 && i < obs.size(); i++) begin
            checks++;
            if (obs[i] != exp_tr[i]) begin
                errors++;
                $display("FAIL lw_trace idx=%0d act=%0d exp=%0d",
                         i, obs[i], exp_tr[i]);
            end
        end
    endtask

    task automatic test_rtype();
        run_instr(6'd0, 0, 0, 0);
        checks++;
        if (obs.size() != 4) begin
            errors++;
            $display("FAIL rtype_cycles act=%0d exp=4", obs.size());
        end
    endtask

    task automatic test_branch_jump();
        run_instr(6'd4, 0, 0, 0);
        checks++;
        if (obs.size() != 3) begin
            errors++;
            $display("FAIL beq_cycles act=%0d exp=3", obs.size());
        end
        run_instr(6'd2, 1, 0, 0);
        run_instr(6'd43, 0, 0, 0);
        checks++;
        if (obs.size() != 4) begin
            errors++;
            $display("FAIL sw_cycles act=%0d exp=4", obs.size());
        end
    endtask

    task automatic test_illegal();
        int exp_len;
`ifdef MC_ADDI_EN
        exp_len = 4;
`else
        exp_len = 2;
`endif
        run_instr(6'd63, 0, 0, 0);
        run_instr(6'd8, 0, 0, 0);
        checks++;
        if (obs.size() != exp_len) begin
            errors++;
            $display("FAIL addi_path act=%0d exp=%0d", obs.size(), exp_len);
        end
    endtask

    task automatic test_reset_midwrite();
        run_instr(6'd43, 0, 2, 1);
        @(negedge clk);
        #1;
        checks++;
        if (bus_if.State !== 4'd0 || act_ctrl() !== 17'd0) begin
            errors++;
            $display("FAIL reset_held st=%0d ctrl=%h exp 0/0",
                     bus_if.State, act_ctrl());
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus_if.State !== 4'd0 || bus_if.IllegalOp !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_abort st=%0d ill=%b exp 0/0",
                     bus_if.State, bus_if.IllegalOp);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[8] = '{6'd0, 6'd35, 6'd43, 6'd4,
                               6'd2, 6'd8, 6'd63, 6'd0};
        logic [5:0] op;
        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 7)];
            if (n % 8 == 7) op = 6'($urandom);
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lw();
        test_rtype();
        test_branch_jump();
        test_illegal();
        test_reset_midwrite();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
